alu_pipe: RTL

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pkg.sv | 39 +++
 rtl/mul_iter.sv | 75 +++++++
 rtl/alu_pipe.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the pipelined MIPS-style ALU.
//   - opcode / funct encodings decoded by alu_pipe
//   - state_t: control FSM encoding (IDLE, MUL, HOLD), also exported on the
//     debug port of alu_pipe
package alu_pkg;

  // Primary opcodes
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;

  // R-type funct codes
  localparam logic [5:0] FN_SLL   = 6'b000000;
  localparam logic [5:0] FN_SRL   = 6'b000010;
  localparam logic [5:0] FN_SRA   = 6'b000011;
  localparam logic [5:0] FN_MFHI  = 6'b010000;
  localparam logic [5:0] FN_MFLO  = 6'b010010;
  localparam logic [5:0] FN_MULTU = 6'b011001;
  localparam logic [5:0] FN_ADD   = 6'b100000;
  localparam logic [5:0] FN_SUB   = 6'b100010;
  localparam logic [5:0] FN_AND   = 6'b100100;
  localparam logic [5:0] FN_OR    = 6'b100101;
  localparam logic [5:0] FN_XOR   = 6'b100110;
  localparam logic [5:0] FN_NOR   = 6'b100111;
  localparam logic [5:0] FN_SLT   = 6'b101010;

  // Control FSM.
  //   IDLE : no result pending, ready for a request
  //   MUL  : iterative multiply in progress, requests blocked
  //   HOLD : a result is presented on the output and waits for out_ready
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/mul_iter.sv
// mul_iter: iterative unsigned shift-add multiplier, one partial product per
// clock, WIDTH iterations in total.
// Ports:
//   clk, rst          clock, synchronous active-high reset (abandons a run)
//   start             pulse: capture a/b and perform the first iteration
//   a, b              multiplicand / multiplier (sampled only on start)
//   busy              a multiply is in progress
//   done              product holds the final value (high for one cycle)
//   product           2*WIDTH-bit running / final product
module mul_iter #(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product
);

  localparam int              CW   = $clog2(WIDTH) + 1;
  localparam logic [CW-1:0]   LAST = CW'(WIDTH);

  logic [WIDTH-1:0]   r_mcand;
  logic [2*WIDTH-1:0] r_prod;
  logic [CW-1:0]      r_cnt;
  logic               r_busy;

  logic [2*WIDTH-1:0] w_step_fresh;
  logic [2*WIDTH-1:0] w_step_run;

  // The product register holds {accumulator, remaining multiplier bits}.
  // Each step adds the multiplicand when the multiplier LSB is set, then
  // shifts the whole register right by one; the adder carry enters at the top.
  function automatic logic [2*WIDTH-1:0] step(input logic [2*WIDTH-1:0] p,
                                              input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] s;
    s = {1'b0, p[2*WIDTH-1:WIDTH]} + (p[0] ? {1'b0, m} : {(WIDTH+1){1'b0}});
    return {s, p[WIDTH-1:1]};
  endfunction

  // The first iteration runs on the start edge straight from the inputs so
  // the final product is registered WIDTH-1 edges later.
  assign w_step_fresh = step({{WIDTH{1'b0}}, b}, a);
  assign w_step_run   = step(r_prod, r_mcand);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
      r_busy  <= 1'b0;
    end else if (start) begin
      r_mcand <= a;
      r_prod  <= w_step_fresh;
      r_cnt   <= CW'(1);
      r_busy  <= 1'b1;
    end else if (r_busy) begin
      if (r_cnt == LAST) begin
        r_busy <= 1'b0;
        r_cnt  <= '0;
      end else begin
        r_prod <= w_step_run;
        r_cnt  <= r_cnt + CW'(1);
      end
    end
  end

  assign busy    = r_busy;
  assign done    = r_busy && (r_cnt == LAST);
  assign product = r_prod;

endmodule

// File: rtl/alu_pipe.sv
// alu_pipe: MIPS-style ALU with a one-deep registered output stage and an
// iterative MULTU unit writing internal HI/LO registers.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid / in_ready      request handshake
//   opcode, funct, shamt     instruction fields
//   in1, in2                 Rs operand, Rt operand / immediate
//   out_valid / out_ready    result handshake
//   result, rw, branch_taken, illegal   registered result fields
//   dbg_state                current control FSM state
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. valid, once raised, holds with stable data until the transfer.
// in_ready = (state != MUL) && (!out_valid || out_ready), so a new request
// may be accepted on the same edge the presented result is consumed.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int SH_W   = $clog2(WIDTH),
  parameter int MUL_EN = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic [SH_W-1:0]  shamt,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             rw,
  output logic             branch_taken,
  output logic             illegal,
  output state_t           dbg_state
);

  localparam bit LP_MUL = (MUL_EN != 0);

  state_t             r_state;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_result;
  logic               r_rw;
  logic               r_br;
  logic               r_ill;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;

  logic               w_accept;
  logic               w_multu;
  logic [WIDTH-1:0]   w_res;
  logic               w_rw;
  logic               w_br;
  logic               w_ill;
  logic [WIDTH-1:0]   w_sum;
  logic [WIDTH-1:0]   w_diff;
  logic               w_mul_busy;
  logic               w_mul_done;
  logic [2*WIDTH-1:0] w_prod;

  assign in_ready = (r_state != MUL) && !w_mul_busy && (!r_out_valid || out_ready);
  assign w_accept = in_valid && in_ready;

  // Carry and overflow fall off the top: modulo 2^WIDTH arithmetic.
  assign w_sum  = in1 + in2;
  assign w_diff = in1 - in2;

  // Single-cycle decode. MULTU only raises w_multu; its result arrives later.
  always_comb begin
    w_res   = '0;
    w_rw    = 1'b0;
    w_br    = 1'b0;
    w_ill   = 1'b0;
    w_multu = 1'b0;
    case (opcode)
      OP_RTYPE: begin
        case (funct)
          FN_ADD: begin w_res = w_sum;         w_rw = 1'b1; end
          FN_SUB: begin w_res = w_diff;        w_rw = 1'b1; end
          FN_AND: begin w_res = in1 & in2;     w_rw = 1'b1; end
          FN_OR:  begin w_res = in1 | in2;     w_rw = 1'b1; end
          FN_XOR: begin w_res = in1 ^ in2;     w_rw = 1'b1; end
          FN_NOR: begin w_res = ~(in1 | in2);  w_rw = 1'b1; end
          FN_SLT: begin
            w_res = {{(WIDTH-1){1'b0}}, ($signed(in1) < $signed(in2))};
            w_rw  = 1'b1;
          end
          FN_SLL: begin w_res = in2 << shamt;  w_rw = 1'b1; end
          FN_SRL: begin w_res = in2 >> shamt;  w_rw = 1'b1; end
          FN_SRA: begin w_res = WIDTH'($signed(in2) >>> shamt); w_rw = 1'b1; end
          FN_MULTU: begin
            if (LP_MUL) w_multu = 1'b1;
            else        w_ill   = 1'b1;
          end
          FN_MFHI: begin
            if (LP_MUL) begin w_res = r_hi; w_rw = 1'b1; end
            else        w_ill = 1'b1;
          end
          FN_MFLO: begin
            if (LP_MUL) begin w_res = r_lo; w_rw = 1'b1; end
            else        w_ill = 1'b1;
          end
          default: w_ill = 1'b1;
        endcase
      end
      OP_LW:   begin w_res = w_sum;  w_rw = 1'b1; end
      OP_SW:   begin w_res = w_sum;  w_rw = 1'b0; end
      OP_BEQ:  begin w_res = w_diff; w_br = (in1 == in2); end
      OP_BNE:  begin w_res = w_diff; w_br = (in1 != in2); end
      default: w_ill = 1'b1;
    endcase
  end

  mul_iter #(.WIDTH(WIDTH)) u_mul (
    .clk     (clk),
    .rst     (rst),
    .start   (w_accept && w_multu),
    .a       (in1),
    .b       (in2),
    .busy    (w_mul_busy),
    .done    (w_mul_done),
    .product (w_prod)
  );

  // Control FSM and output stage. HOLD means a result is being presented;
  // from HOLD a consumed result returns to IDLE unless a new single-cycle
  // request is accepted on the same edge, which keeps the stage full.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_rw        <= 1'b0;
      r_br        <= 1'b0;
      r_ill       <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
    end else begin
      case (r_state)
        MUL: begin
          if (w_mul_done) begin
            r_hi        <= w_prod[2*WIDTH-1:WIDTH];
            r_lo        <= w_prod[WIDTH-1:0];
            r_result    <= w_prod[WIDTH-1:0];
            r_rw        <= 1'b0;
            r_br        <= 1'b0;
            r_ill       <= 1'b0;
            r_out_valid <= 1'b1;
            r_state     <= HOLD;
          end
        end
        default: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= IDLE;
          end
          if (w_accept) begin
            if (w_multu) begin
              r_state <= MUL;
            end else begin
              r_result    <= w_res;
              r_rw        <= w_rw;
              r_br        <= w_br;
              r_ill       <= w_ill;
              r_out_valid <= 1'b1;
              r_state     <= HOLD;
            end
          end
        end
      endcase
    end
  end

  assign out_valid    = r_out_valid;
  assign result       = r_result;
  assign rw           = r_rw;
  assign branch_taken = r_br;
  assign illegal      = r_ill;
  assign dbg_state    = r_state;

endmodule
